// File: rtl/mmm_pkg.sv
// Shared types for the branch resolution slice.
// Holds the FSM state encoding and the predictor-update entry.
package mmm_pkg;

  localparam int MMM_XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  typedef struct packed {
    logic [MMM_XLEN-1:0] pc;
    logic [MMM_XLEN-1:0] target;
    logic                taken;
  } upd_entry_t;

  function automatic logic [MMM_XLEN-1:0] seq_pc(
    input logic [MMM_XLEN-1:0] pc
  );
    return pc + MMM_XLEN'(4);
  endfunction

endpackage

// File: rtl/branch_upd_fifo.sv
// Predictor-update FIFO with wrap-bit pointers.
// A push into a full FIFO survives only if a pop frees the slot.
module branch_upd_fifo
  import mmm_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = upd_entry_t
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  entry_t                 entry_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output entry_t                 head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o
);

  localparam int AW = $clog2(DEPTH);

  entry_t      mem_q [DEPTH];
  logic [AW:0] wptr_q;
  logic [AW:0] wptr_d;
  logic [AW:0] rptr_q;
  logic [AW:0] rptr_d;
  logic        ovf_q;
  logic        ovf_d;
  logic        empty;
  logic        full;
  logic        do_pop;
  logic        do_push;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    if (do_push) begin
      wptr_d = wptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end
    if (push_i && full && !do_pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage needs no reset; valid_o gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= entry_i;
    end
  end

  assign valid_o    = ~empty;
  assign head_o     = mem_q[rptr_q[AW-1:0]];
  assign count_o    = wptr_q - rptr_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/branch_resolve_ctl.sv
// Branch resolution control: flush/redirect FSM,
// mispredict counter and predictor-update queue.
module branch_resolve_ctl
  import mmm_pkg::*;
#(
  parameter int XLEN      = MMM_XLEN,
  parameter int UPD_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            res_valid_i,
  input  logic            res_taken_i,
  input  logic            res_mispredict_i,
  input  logic [XLEN-1:0] res_pc_i,
  input  logic [XLEN-1:0] res_target_i,
  output logic            bu_stall_o,
  output logic            flush_o,
  output logic            redirect_valid_o,
  input  logic            redirect_ready_i,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            upd_valid_o,
  input  logic            upd_ready_i,
  output logic [XLEN-1:0] upd_pc_o,
  output logic [XLEN-1:0] upd_target_o,
  output logic            upd_taken_o,
  output logic [15:0]     mispred_cnt_o,
  output logic            err_overflow_o
);

  localparam int CW = $clog2(UPD_DEPTH) + 1;

  state_e          state_q;
  state_e          state_d;
  logic [XLEN-1:0] rpc_q;
  logic [XLEN-1:0] rpc_d;
  logic [15:0]     cnt_q;
  logic [15:0]     cnt_d;

  logic            accept;
  logic            mis_acc;
  upd_entry_t      push_ent;
  upd_entry_t      head;
  logic            fifo_vld;
  logic [CW-1:0]   fifo_cnt;

  // Results seen outside IDLE are wrong-path and ignored.
  assign accept  = res_valid_i & (state_q == ST_IDLE);
  assign mis_acc = accept & res_mispredict_i;

  assign push_ent.pc     = MMM_XLEN'(res_pc_i);
  assign push_ent.target = MMM_XLEN'(res_target_i);
  assign push_ent.taken  = res_taken_i;

  always_comb begin
    state_d = state_q;
    rpc_d   = rpc_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (mis_acc) begin
          state_d = ST_FLUSH;
          rpc_d   = res_taken_i ? res_target_i
                                : res_pc_i + XLEN'(4);
        end
      end
      (state_q == ST_FLUSH): begin
        state_d = ST_REDIRECT;
      end
      (state_q == ST_REDIRECT): begin
        if (redirect_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (mis_acc && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      rpc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rpc_q   <= rpc_d;
      cnt_q   <= cnt_d;
    end
  end

  branch_upd_fifo #(
    .DEPTH   (UPD_DEPTH),
    .entry_t (upd_entry_t)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .push_i     (accept),
    .entry_i    (push_ent),
    .pop_i      (upd_ready_i),
    .valid_o    (fifo_vld),
    .head_o     (head),
    .count_o    (fifo_cnt),
    .overflow_o (err_overflow_o)
  );

  assign flush_o          = (state_q == ST_FLUSH);
  assign redirect_valid_o = (state_q == ST_REDIRECT);
  assign redirect_pc_o    = rpc_q;
  assign mispred_cnt_o    = cnt_q;

  assign bu_stall_o = (state_q != ST_IDLE) ||
                      (fifo_cnt >= CW'(UPD_DEPTH - 1));

  assign upd_valid_o  = fifo_vld;
  assign upd_pc_o     = fifo_vld ? XLEN'(head.pc) : '0;
  assign upd_target_o = fifo_vld ? XLEN'(head.target) : '0;
  assign upd_taken_o  = fifo_vld & head.taken;

endmodule

// File: tb/tb_branch_resolve_ctl.sv
// Directed self-checking bench for branch_resolve_ctl.
// Inputs change 1ns after posedge; outputs checked there.
module tb_branch_resolve_ctl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        res_valid_i;
  logic        res_taken_i;
  logic        res_mispredict_i;
  logic [31:0] res_pc_i;
  logic [31:0] res_target_i;
  logic        bu_stall_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic        redirect_ready_i;
  logic [31:0] redirect_pc_o;
  logic        upd_valid_o;
  logic        upd_ready_i;
  logic [31:0] upd_pc_o;
  logic [31:0] upd_target_o;
  logic        upd_taken_o;
  logic [15:0] mispred_cnt_o;
  logic        err_overflow_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  branch_resolve_ctl dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .res_valid_i      (res_valid_i),
    .res_taken_i      (res_taken_i),
    .res_mispredict_i (res_mispredict_i),
    .res_pc_i         (res_pc_i),
    .res_target_i     (res_target_i),
    .bu_stall_o       (bu_stall_o),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_ready_i (redirect_ready_i),
    .redirect_pc_o    (redirect_pc_o),
    .upd_valid_o      (upd_valid_o),
    .upd_ready_i      (upd_ready_i),
    .upd_pc_o         (upd_pc_o),
    .upd_target_o     (upd_target_o),
    .upd_taken_o      (upd_taken_o),
    .mispred_cnt_o    (mispred_cnt_o),
    .err_overflow_o   (err_overflow_o)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic res(input logic        tk,
                     input logic        mp,
                     input logic [31:0] pc,
                     input logic [31:0] tg);
    res_valid_i      = 1'b1;
    res_taken_i      = tk;
    res_mispredict_i = mp;
    res_pc_i         = pc;
    res_target_i     = tg;
    step();
    res_valid_i      = 1'b0;
  endtask

  initial begin
    rst_n_i          = 1'b0;
    res_valid_i      = 1'b0;
    res_taken_i      = 1'b0;
    res_mispredict_i = 1'b0;
    res_pc_i         = '0;
    res_target_i     = '0;
    redirect_ready_i = 1'b0;
    upd_ready_i      = 1'b0;
    step();
    step();

    chk("rst_flush", flush_o, 0);
    chk("rst_rvalid", redirect_valid_o, 0);
    chk("rst_uvalid", upd_valid_o, 0);
    chk("rst_stall", bu_stall_o, 0);
    chk("rst_rpc", redirect_pc_o, 0);
    chk("rst_cnt", mispred_cnt_o, 0);
    chk("rst_err", err_overflow_o, 0);
    chk("rst_upc", upd_pc_o, 0);
    rst_n_i = 1'b1;
    step();

    // Correct prediction is queued, visible next cycle only
    res_valid_i      = 1'b1;
    res_taken_i      = 1'b1;
    res_mispredict_i = 1'b0;
    res_pc_i         = 32'h100;
    res_target_i     = 32'h200;
    #1;
    chk("push_not_comb", upd_valid_o, 0);
    step();
    res_valid_i = 1'b0;
    chk("ok_noflush", flush_o, 0);
    chk("ok_uvalid", upd_valid_o, 1);
    chk("ok_upc", upd_pc_o, 32'h100);
    chk("ok_utgt", upd_target_o, 32'h200);
    chk("ok_utaken", upd_taken_o, 1);
    upd_ready_i = 1'b1;
    step();
    chk("ok_popped", upd_valid_o, 0);

    // Taken mispredict, fetch ready
    redirect_ready_i = 1'b1;
    res(1'b1, 1'b1, 32'h100, 32'h400);
    chk("tk_flush_t1", flush_o, 1);
    chk("tk_rvalid_t1", redirect_valid_o, 0);
    chk("tk_stall_t1", bu_stall_o, 1);
    chk("tk_cnt", mispred_cnt_o, 1);
    step();
    chk("tk_flush_t2", flush_o, 0);
    chk("tk_rvalid_t2", redirect_valid_o, 1);
    chk("tk_rpc_t2", redirect_pc_o, 32'h400);
    step();
    chk("tk_rvalid_t3", redirect_valid_o, 0);
    chk("tk_stall_t3", bu_stall_o, 0);
    chk("tk_upd_drained", upd_valid_o, 0);

    // Not-taken mispredict at top of memory, fetch stalls
    redirect_ready_i = 1'b0;
    upd_ready_i      = 1'b0;
    res(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1234);
    chk("nt_flush", flush_o, 1);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("nt_rvalid_hold", redirect_valid_o, 1);
      chk("nt_rpc_wrap", redirect_pc_o, 32'h0);
      if (i == 0) begin
        res(1'b1, 1'b0, 32'h500, 32'h600);
      end else begin
        step();
      end
    end
    redirect_ready_i = 1'b1;
    step();
    chk("nt_idle", redirect_valid_o, 0);
    chk("nt_cnt", mispred_cnt_o, 2);
    chk("nt_upc", upd_pc_o, 32'hFFFF_FFFC);
    chk("nt_utgt", upd_target_o, 32'h1234);
    chk("nt_utaken", upd_taken_o, 0);
    upd_ready_i = 1'b1;
    step();
    chk("wrongpath_dropped", upd_valid_o, 0);
    upd_ready_i = 1'b0;

    // Fill, overflow, then drain in order
    res(1'b1, 1'b0, 32'h10, 32'h11);
    res(1'b0, 1'b0, 32'h20, 32'h21);
    chk("fill2_nostall", bu_stall_o, 0);
    res(1'b1, 1'b0, 32'h30, 32'h31);
    chk("fill3_stall", bu_stall_o, 1);
    res(1'b0, 1'b0, 32'h40, 32'h41);
    chk("fill4_noerr", err_overflow_o, 0);
    res(1'b1, 1'b0, 32'h50, 32'h51);
    chk("ovf_err", err_overflow_o, 1);
    upd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", upd_valid_o, 1);
      chk("drain_pc", upd_pc_o, 32'h10 * (i + 1));
      chk("drain_taken", upd_taken_o, (i % 2) == 0);
      step();
    end
    chk("drain_empty", upd_valid_o, 0);
    chk("ovf_sticky", err_overflow_o, 1);
    upd_ready_i = 1'b0;

    // Reset clears the sticky flag before the full push+pop test
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    step();
    chk("rst2_err", err_overflow_o, 0);
    res(1'b1, 1'b0, 32'h60, 32'h61);
    res(1'b1, 1'b0, 32'h70, 32'h71);
    res(1'b1, 1'b0, 32'h80, 32'h81);
    res(1'b1, 1'b0, 32'h90, 32'h91);
    upd_ready_i = 1'b1;
    res(1'b1, 1'b0, 32'hA0, 32'hA1);
    upd_ready_i = 1'b0;
    chk("pp_noerr", err_overflow_o, 0);
    chk("pp_stall", bu_stall_o, 1);
    upd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pp_valid", upd_valid_o, 1);
      chk("pp_pc", upd_pc_o, 32'h70 + 32'h10 * i);
      step();
    end
    chk("pp_empty", upd_valid_o, 0);

    // Saturation: preload the counter near its ceiling
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    chk("sat_preload", mispred_cnt_o, 16'hFFFE);
    redirect_ready_i = 1'b1;
    res(1'b1, 1'b1, 32'h100, 32'h800);
    step();
    step();
    chk("sat_ffff", mispred_cnt_o, 16'hFFFF);
    res(1'b1, 1'b1, 32'h100, 32'h800);
    step();
    step();
    chk("sat_hold", mispred_cnt_o, 16'hFFFF);
    step();

    // Reset during REDIRECT with two queued entries
    upd_ready_i      = 1'b0;
    redirect_ready_i = 1'b0;
    res(1'b1, 1'b0, 32'h11, 32'h22);
    res(1'b1, 1'b1, 32'h300, 32'h700);
    step();
    chk("pre_rst_rvalid", redirect_valid_o, 1);
    chk("pre_rst_uvalid", upd_valid_o, 1);
    chk("pre_rst_rpc", redirect_pc_o, 32'h700);
    rst_n_i = 1'b0;
    #1;
    chk("async_rvalid", redirect_valid_o, 0);
    step();
    rst_n_i = 1'b1;
    step();
    chk("post_rvalid", redirect_valid_o, 0);
    chk("post_uvalid", upd_valid_o, 0);
    chk("post_err", err_overflow_o, 0);
    chk("post_cnt", mispred_cnt_o, 0);
    chk("post_rpc", redirect_pc_o, 0);
    step();
    chk("post_flush", flush_o, 0);
    chk("post_stall", bu_stall_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
